spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_master_tick.sv | 34 +++
 rtl/spi_master.sv | 166 ++++++++++++++++
 tb/tb_spi_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM states, frame geometry, R/W command bit encoding.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } spi_state_e;

  localparam int   FRAME_BITS = 16;
  localparam int   RW_BIT     = 7;
  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;

  // Byte 0 carries the command, byte 1 the write data (zero for reads).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                        input logic [6:0] addr,
                                                        input logic [7:0] data);
    logic [7:0] cmd;
    cmd         = {1'b0, addr};
    cmd[RW_BIT] = wr ? RW_WRITE : RW_READ;
    return {cmd, (wr ? data : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_master_tick.sv
// SCK timebase: CLK_DIV-cycle half-period counter issuing one-cycle rise/fall strobes.
// Latency: first strobe CLK_DIV cycles after en rises; no backpressure, clears whenever en is low.
module spi_master_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_cnt_q;
  logic       phase_q;
  logic       tc;

  assign tc       = en && (div_cnt_q == 8'(CLK_DIV - 1));
  assign rise_stb = tc && !phase_q;
  assign fall_stb = tc && phase_q;

  // phase_q tracks the SCK level the current half-period is holding.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en) begin
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else if (tc) begin
      div_cnt_q <= '0;
      phase_q   <= ~phase_q;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 register master: 16-bit {R/W,addr,data} frame, MSB first; SPI_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchronizer.
// Latency: done_o 1+33*CLK_DIV cycles after acceptance; backpressure: req_ready_o low until the CS gap has elapsed.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       spi_clk_o,
  output logic       spi_ncs_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
);

  // The IDLE cycle that accepts a back-to-back request also keeps CS high.
  localparam int GAP_LEN = (CS_GAP > 1) ? CS_GAP - 1 : 1;

  spi_state_e            state_q, state_nxt;
  logic [FRAME_BITS-1:0] frame_in;
  logic [FRAME_BITS-2:0] frame_q;
  logic [3:0]            bit_cnt_q;
  logic [7:0]            gap_cnt_q, rx_sr_q, rdata_q;
  logic                  last_q, is_read_q;
  logic                  sck_q, ncs_q, mosi_q, done_q;
  logic                  accept, to_gap, shift_adv, sck_nxt;
  logic                  tick_en, rise_stb, fall_stb;
  logic                  cap_rise, cap_stb, miso_s;

  assign frame_in    = build_frame(req_write_i, req_addr_i, req_data_i);
  assign tick_en     = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
  assign cap_rise    = (state_q == ST_SHIFT) && rise_stb && !last_q && bit_cnt_q[3];
  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign spi_clk_o   = sck_q;
  assign spi_ncs_o   = ncs_q;
  assign spi_mosi_o  = mosi_q;

  spi_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en       (tick_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

`ifdef SPI_MASTER_MISO_SYNC_EN
  if (CLK_DIV < 3) begin : g_div_check
    $error("spi_master: CLK_DIV must be >= 3 when the MISO synchronizer is enabled");
  end

  logic [1:0] miso_sync_q;
  logic [1:0] cap_dly_q;

  // Sample point trails the SCK-rise edge by the synchronizer depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miso_sync_q <= '0;
      cap_dly_q   <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], spi_miso_i};
      cap_dly_q   <= {cap_dly_q[0], cap_rise};
    end
  end

  assign miso_s  = miso_sync_q[1];
  assign cap_stb = cap_dly_q[1];
`else
  assign miso_s  = spi_miso_i;
  assign cap_stb = cap_rise;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    to_gap    = 1'b0;
    shift_adv = 1'b0;
    sck_nxt   = sck_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (rise_stb) begin
          sck_nxt   = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // After the 16th fall, the next rise strobe closes the trailing low half instead.
        if (rise_stb) begin
          if (last_q) begin
            to_gap    = 1'b1;
            state_nxt = ST_GAP;
          end else begin
            sck_nxt = 1'b1;
          end
        end else if (fall_stb) begin
          sck_nxt   = 1'b0;
          shift_adv = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'(GAP_LEN - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rx_sr_q   <= '0;
      rdata_q   <= '0;
      last_q    <= 1'b0;
      is_read_q <= 1'b0;
      sck_q     <= 1'b0;
      ncs_q     <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= to_gap;
      sck_q     <= sck_nxt;
      ncs_q     <= (state_nxt == ST_IDLE) || (state_nxt == ST_GAP);
      gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 8'd1 : 8'd0;
      if (accept) begin
        frame_q   <= frame_in[FRAME_BITS-2:0];
        mosi_q    <= frame_in[FRAME_BITS-1];
        is_read_q <= ~req_write_i;
        bit_cnt_q <= '0;
        last_q    <= 1'b0;
      end
      // Zero fill makes MOSI settle low on the 16th fall.
      if (shift_adv) begin
        mosi_q  <= frame_q[FRAME_BITS-2];
        frame_q <= {frame_q[FRAME_BITS-3:0], 1'b0};
        if (bit_cnt_q == 4'd15) last_q    <= 1'b1;
        else                    bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      if (cap_stb) rx_sr_q <= {rx_sr_q[6:0], miso_s};
      if (to_gap && is_read_q) rdata_q <= rx_sr_q;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of register writes/reads plus back-to-back, abort and input-hold sequences.
module tb_spi_master;

`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int CD = 3;
`else
  localparam int CD = 2;
`endif
  localparam int CSG     = 4;
  localparam int TXN_CYC = 33 * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       done, busy;
  logic [7:0] rdata;
  logic       sck, ncs, mosi, miso;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CD), .CS_GAP(CSG)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .done_o      (done),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .spi_clk_o   (sck),
    .spi_ncs_o   (ncs),
    .spi_mosi_o  (mosi),
    .spi_miso_i  (miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor and mode-0 slave: slave shifts slv_word out MSB first, advancing on each SCK fall.
  int          rises = 0, falls = 0, hi_viol = 0;
  logic [15:0] mosi_cap = '0;
  logic [15:0] slv_word = '0;
  logic        ncs_p = 1'b1, sck_p = 1'b0, mosi_p = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ncs_p && !ncs) begin
        rises    = 0;
        falls    = 0;
        mosi_cap = '0;
      end
      if (!ncs && !sck_p && sck) begin
        mosi_cap = {mosi_cap[14:0], mosi};
        rises++;
      end
      if (!ncs && sck_p && !sck) falls++;
      if (ncs && ncs_p && ((sck !== sck_p) || (mosi !== mosi_p))) hi_viol++;
    end
    ncs_p  = ncs;
    sck_p  = sck;
    mosi_p = mosi;
  end

  always_comb miso = (falls < 16) ? slv_word[4'(15 - falls)] : 1'b0;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [7:0]  slv;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic start_req(input logic wr, input logic [6:0] a, input logic [7:0] d);
    int g = 0;
    @(negedge clk);
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lat0, input int low0,
                           output int lat, output int low, output int rdy, output logic [7:0] rd);
    bit got = 1'b0;
    int n   = 0;
    lat = lat0;
    low = low0;
    rdy = 0;
    rd  = '0;
    while (!got && n < 40 * CD + 40) begin
      @(negedge clk);
      n++;
      lat++;
      if (done) begin
        got = 1'b1;
        rd  = rdata;
      end else begin
        if (!ncs) low++;
        if (req_ready || !busy) rdy++;
      end
    end
    if (!got) lat = 0;
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int lat, low, rdy;
    logic [7:0] rd;
    slv_word = {8'h00, v.slv};
    start_req(v.wr, v.addr, v.data);
    req_valid = 1'b0;
    req_write = ~v.wr;
    req_addr  = ~v.addr;
    req_data  = ~v.data;
    wait_done(0, 0, lat, low, rdy, rd);
    chk({tag, "_done_lat"}, 32'(lat), 32'(1 + TXN_CYC));
    chk({tag, "_ncs_low"}, 32'(low), 32'(TXN_CYC));
    chk({tag, "_rises"}, 32'(rises), 32'd16);
    chk({tag, "_mosi"}, 32'(mosi_cap), 32'(v.exp_mosi));
    chk({tag, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
    chk({tag, "_busy_ready"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, low, rdy, hi, r, g, dn;
    logic [7:0] rd;
    logic sp;

    vecs[0] = '{1'b1, 7'h15, 8'hA5, 8'h00, 16'h15A5, 8'h00};
    vecs[1] = '{1'b0, 7'h42, 8'h99, 8'h3C, 16'hC200, 8'h3C};
    vecs[2] = '{1'b1, 7'h7F, 8'h00, 8'h5A, 16'h7F00, 8'h3C};
    vecs[3] = '{1'b0, 7'h01, 8'h00, 8'h81, 16'h8100, 8'h81};
    vecs[4] = '{1'b0, 7'h00, 8'h00, 8'hFF, 16'h8000, 8'hFF};
    vecs[5] = '{1'b1, 7'h00, 8'hFF, 8'h00, 16'h00FF, 8'hFF};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ncs", 32'(ncs), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: valid stays high across two writes.
    slv_word = '0;
    start_req(1'b1, 7'h2A, 8'h3C);
    req_write = 1'b1;
    req_addr  = 7'h55;
    req_data  = 8'hC3;
    wait_done(0, 0, lat, low, rdy, rd);
    chk("b2b_a_lat", 32'(lat), 32'(1 + TXN_CYC));
    chk("b2b_a_mosi", 32'(mosi_cap), 32'h2A3C);
    chk("b2b_a_ready", 32'(rdy), 32'd0);
    hi = 0;
    while (ncs && hi < 50) begin
      hi++;
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 7'h00;
        req_data  = 8'h00;
      end
      @(negedge clk);
    end
    chk("b2b_ncs_gap", 32'(hi), 32'(CSG));
    wait_done(1, 1, lat, low, rdy, rd);
    chk("b2b_b_lat", 32'(lat), 32'(1 + TXN_CYC));
    chk("b2b_b_ncs_low", 32'(low), 32'(TXN_CYC));
    chk("b2b_b_mosi", 32'(mosi_cap), 32'h55C3);
    chk("b2b_b_ready", 32'(rdy), 32'd0);

    // Abort a read with reset right after the 5th SCK rise.
    slv_word = {8'h00, 8'hE7};
    start_req(1'b0, 7'h33, 8'h00);
    req_valid = 1'b0;
    r  = 0;
    g  = 0;
    sp = sck;
    while (r < 5 && g < 40 * CD) begin
      @(negedge clk);
      g++;
      if (sck && !sp) r++;
      sp = sck;
    end
    chk("abort_rise5_seen", 32'(r), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ncs", 32'(ncs), 32'd1);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 40 * CD; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    do_vec(vecs[1], "post_abort");

    chk("sck_mosi_quiet_ncs_high", 32'(hi_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
